dest_reg_pipe: RTL and testbench
================================

DEST_REG_PIPE -- requirements
Module: dest_reg_pipe

Interface
REQ-001 Parameter REG_W, default 5, register address width.
REQ-002 Parameter DEPTH, default 3, pipeline stages from destination select to writeback (legal range 1..8).
REQ-003 Parameter LINK_REG, default 31, address written for link (jal-type) destinations.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  instruction present at decode this cycle.
REQ-007 reg_write  input  1  instruction writes a register.
REQ-008 reg_dst  input  2  destination mode: 00 rt, 01 rd, 10 LINK_REG, 11 rt.
REQ-009 rt_addr, rd_addr  input  REG_W each  candidate destination fields.
REQ-010 src_a, src_b  input  REG_W each  source registers of the decoding instruction.
REQ-011 stall  input  1  hold the pipeline.
REQ-012 flush  input  1  kill all in-flight entries.
REQ-013 dest_out  output  REG_W  combinational selected destination.
REQ-014 wb_valid  output  1  writeback strobe for the oldest stage.
REQ-015 wb_dest  output  REG_W  writeback register address.
REQ-016 hazard_a, hazard_b  output  1 each  source matches an in-flight destination.
REQ-017 inflight  output  4  count of valid stages (0..DEPTH).

Function
REQ-018 dest_out SHALL follow reg_dst selection with zero latency, independent of in_valid.
REQ-019 Each stage SHALL hold {valid, dest}; stage 0 loads valid = in_valid & reg_write & (dest_out != 0), dest = dest_out.
REQ-020 Writes to register 0 SHALL never enter the pipeline as valid.
REQ-021 With stall=0 and flush=0, every stage k SHALL load stage k-1 each cycle; an entry accepted at edge n SHALL appear on wb_valid/wb_dest in the cycle after edge n+DEPTH-1 (latency DEPTH cycles).
REQ-022 wb_valid/wb_dest SHALL be the registered outputs of stage DEPTH-1.
REQ-023 With stall=1 all stages SHALL hold and wb_valid SHALL be forced 0 while stall is high, so no entry writes back twice.
REQ-024 On stall release, the held oldest entry SHALL be presented on wb_valid in the first non-stalled cycle.
REQ-025 flush=1 SHALL clear every stage valid at the next edge; flush SHALL have priority over stall and over the new input.
REQ-026 hazard_a SHALL be 1 when src_a != 0 and any valid stage has dest == src_a; hazard_b likewise for src_b; combinational.
REQ-027 Hazards SHALL be evaluated against the current stage contents, not the entry being loaded this cycle.
REQ-028 inflight SHALL equal the number of stages with valid=1, registered, updated on the same edge as the stages.
REQ-029 Simultaneous matching destinations in several stages SHALL raise the hazard once (OR); no priority encoding required.

Reset
REQ-030 reset SHALL clear all stage valids and dests to 0 at the next rising edge, overriding flush, stall and input.
REQ-031 After reset wb_valid=0, wb_dest=0, inflight=0, hazard_a=hazard_b=0.
REQ-032 reset asserted mid-operation SHALL discard all in-flight entries with no writeback strobe.

Structure
REQ-033 A shared package SHALL hold the reg_dst encodings (RD_RT, RD_RD, RD_LINK) and the zero-register constant.
REQ-034 One sub-module dest_mux SHALL implement the REQ-018 selection; all stage registers, hazard compare and counting stay in dest_reg_pipe.

Verification
REQ-035 Select: rt=01010, rd=11111, reg_dst 00/01/10 -> dest_out 01010/11111/11111(LINK_REG=31).
REQ-036 Latency: DEPTH=3, accept rd=00101 at cycle 0 -> wb_valid=1, wb_dest=00101 exactly at cycle 3, inflight 1 during cycles 1..3.
REQ-037 Zero write: reg_dst=00, rt=00000, reg_write=1 -> no wb_valid, inflight stays 0, no hazard on src_a=0.
REQ-038 Hazard: in-flight dest 01000, src_a=01000, src_b=01001 -> hazard_a=1, hazard_b=0 until entry leaves stage DEPTH-1.
REQ-039 Stall: entry in oldest stage, stall 2 cycles -> wb_valid 0 for both, single wb_valid pulse after release.
REQ-040 Flush/reset: three valid entries, flush=1 with stall=1 -> inflight 0 next cycle, no writeback; repeat with reset -> same.

Source files
------------

// File: rtl/dest_reg_pipe_pkg.sv
// Shared encodings and helpers for the destination-register tracking pipeline.
// Holds the reg_dst field encoding, the zero-register constant and a valid counter.
package dest_reg_pipe_pkg;

  typedef enum logic [1:0] {
    RD_RT     = 2'b00,
    RD_RD     = 2'b01,
    RD_LINK   = 2'b10,
    RD_RT_ALT = 2'b11
  } reg_dst_e;

  localparam int ZERO_REG   = 0;
  localparam int INFLIGHT_W = 4;
  localparam int MAX_DEPTH  = 8;

  // Population count of a stage-valid vector, zero-extended to the maximum depth.
  function automatic logic [INFLIGHT_W-1:0] count_valid(input logic [MAX_DEPTH-1:0] v);
    logic [INFLIGHT_W-1:0] n;
    n = '0;
    for (int k = 0; k < MAX_DEPTH; k++) begin
      n = n + INFLIGHT_W'(v[k]);
    end
    return n;
  endfunction

endpackage

// File: rtl/dest_reg_pipe_dest_mux.sv
// Destination selector: picks rt, rd or the link register from the reg_dst field.
// Purely combinational so the decode stage sees the destination with no latency.
module dest_mux
  import dest_reg_pipe_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int LINK_REG = 31
) (
  input  logic [1:0]       reg_dst,
  input  logic [REG_W-1:0] rt_addr,
  input  logic [REG_W-1:0] rd_addr,
  output logic [REG_W-1:0] dest
);

  always_comb begin
    dest = rt_addr;
    case (reg_dst_e'(reg_dst))
      RD_RD:   dest = rd_addr;
      RD_LINK: dest = REG_W'(LINK_REG);
      default: dest = rt_addr;
    endcase
  end

endmodule

// File: rtl/dest_reg_pipe.sv
// Tracks destination registers of in-flight instructions from decode to writeback,
// producing the writeback strobe, source-hazard flags and an occupancy count.
module dest_reg_pipe
  import dest_reg_pipe_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int DEPTH    = 3,
  parameter int LINK_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             reg_write,
  input  logic [1:0]       reg_dst,
  input  logic [REG_W-1:0] rt_addr,
  input  logic [REG_W-1:0] rd_addr,
  input  logic [REG_W-1:0] src_a,
  input  logic [REG_W-1:0] src_b,
  input  logic             stall,
  input  logic             flush,
  output logic [REG_W-1:0] dest_out,
  output logic             wb_valid,
  output logic [REG_W-1:0] wb_dest,
  output logic             hazard_a,
  output logic             hazard_b,
  output logic [3:0]       inflight
);

  logic [REG_W-1:0] dest_sel;
  logic             accept;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [REG_W-1:0] dest_q [DEPTH];
  logic [REG_W-1:0] dest_d [DEPTH];
  logic [3:0]       inflight_q, inflight_d;

  logic             hazard_a_c, hazard_b_c;

  dest_mux #(
    .REG_W    (REG_W),
    .LINK_REG (LINK_REG)
  ) u_dest_mux (
    .reg_dst (reg_dst),
    .rt_addr (rt_addr),
    .rd_addr (rd_addr),
    .dest    (dest_sel)
  );

  assign dest_out = dest_sel;

  // Writes to the zero register are architecturally discarded, so never track them.
  assign accept = in_valid & reg_write & (dest_sel != REG_W'(ZERO_REG));

  // Next-state for the stage shift register; flush wins over stall and new input.
  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < DEPTH; k++) begin
      dest_d[k] = dest_q[k];
    end
    if (flush) begin
      valid_d = '0;
    end else if (!stall) begin
      valid_d[0] = accept;
      dest_d[0]  = dest_sel;
      for (int k = 1; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        dest_d[k]  = dest_q[k-1];
      end
    end
    inflight_d = count_valid(MAX_DEPTH'(valid_d));
  end

  // Stage registers: reset clears both valids and destinations.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= '0;
      inflight_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        dest_q[k] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      inflight_q <= inflight_d;
      for (int k = 0; k < DEPTH; k++) begin
        dest_q[k] <= dest_d[k];
      end
    end
  end

  // Hazards look only at current stage contents, never at the entry being loaded.
  always_comb begin
    hazard_a_c = 1'b0;
    hazard_b_c = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_q[k] && (dest_q[k] == src_a)) hazard_a_c = 1'b1;
      if (valid_q[k] && (dest_q[k] == src_b)) hazard_b_c = 1'b1;
    end
    if (src_a == REG_W'(ZERO_REG)) hazard_a_c = 1'b0;
    if (src_b == REG_W'(ZERO_REG)) hazard_b_c = 1'b0;
  end

  assign hazard_a = hazard_a_c;
  assign hazard_b = hazard_b_c;

  // A held oldest entry is masked while stalled so it strobes exactly once.
  assign wb_valid = valid_q[DEPTH-1] & ~stall & ~reset;
  assign wb_dest  = dest_q[DEPTH-1];
  assign inflight = inflight_q;

endmodule

// File: tb/tb_dest_reg_pipe.sv
// Self-checking bench for dest_reg_pipe: directed scenarios plus randomized traffic
// compared against an entry-list model (each entry carries its dest and its age).
module tb_dest_reg_pipe;

  localparam int DEPTH = 3;
  localparam int LINK  = 31;

  logic       clk = 1'b0;
  logic       reset, in_valid, reg_write, stall, flush;
  logic [1:0] reg_dst;
  logic [4:0] rt_addr, rd_addr, src_a, src_b;
  logic [4:0] dest_out, wb_dest;
  logic       wb_valid, hazard_a, hazard_b;
  logic [3:0] inflight;

  int errors = 0;
  int checks = 0;

  // Model: one list element per accepted instruction still in flight.
  logic [4:0] m_dest[$];
  int         m_age[$];

  dest_reg_pipe #(.REG_W(5), .DEPTH(DEPTH), .LINK_REG(LINK)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .reg_write(reg_write),
    .reg_dst(reg_dst), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .src_a(src_a), .src_b(src_b), .stall(stall), .flush(flush),
    .dest_out(dest_out), .wb_valid(wb_valid), .wb_dest(wb_dest),
    .hazard_a(hazard_a), .hazard_b(hazard_b), .inflight(inflight)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] sel_model(input logic [1:0] md, input logic [4:0] rt, input logic [4:0] rd);
    if (md == 2'b01) return rd;
    if (md == 2'b10) return 5'(LINK);
    return rt;
  endfunction

  function automatic logic m_wb_valid();
    if (stall || reset) return 1'b0;
    foreach (m_age[i]) if (m_age[i] == DEPTH-1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [4:0] m_wb_dest();
    foreach (m_age[i]) if (m_age[i] == DEPTH-1) return m_dest[i];
    return 5'd0;
  endfunction

  function automatic logic m_hazard(input logic [4:0] s);
    if (s == 5'd0) return 1'b0;
    foreach (m_dest[i]) if (m_dest[i] == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_inflight();
    return 4'(m_dest.size());
  endfunction

  task automatic model_edge();
    logic [4:0] nd[$];
    int         na[$];
    logic       acc;
    acc = in_valid && reg_write && (sel_model(reg_dst, rt_addr, rd_addr) != 5'd0);
    if (reset || flush) begin
      m_dest.delete();
      m_age.delete();
    end else if (!stall) begin
      foreach (m_age[i]) begin
        if (m_age[i] < DEPTH-1) begin
          nd.push_back(m_dest[i]);
          na.push_back(m_age[i] + 1);
        end
      end
      if (acc) begin
        nd.push_back(sel_model(reg_dst, rt_addr, rd_addr));
        na.push_back(0);
      end
      m_dest = nd;
      m_age  = na;
    end
  endtask

  task automatic drive(input logic iv, input logic rw, input logic [1:0] md,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [4:0] sa, input logic [4:0] sb,
                       input logic st, input logic fl, input logic rs);
    @(negedge clk);
    in_valid = iv; reg_write = rw; reg_dst = md; rt_addr = rt; rd_addr = rd;
    src_a = sa; src_b = sb; stall = st; flush = fl; reset = rs;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle(input logic [4:0] sa, input logic [4:0] sb);
    drive(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, sa, sb, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 2'b01, 5'd3, 5'd7, 5'd7, 5'd3, 1'b0, 1'b0, 1'b1);
    tick();
    idle(5'd7, 5'd3);
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got=%b want=0", wb_valid); end
    checks++; if (wb_dest !== 5'd0) begin errors++; $display("FAIL reset_wb_dest got=%0d want=0", wb_dest); end
    checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL reset_inflight got=%0d want=0", inflight); end
    checks++; if (hazard_a !== 1'b0) begin errors++; $display("FAIL reset_hazard_a got=%b want=0", hazard_a); end
    checks++; if (hazard_b !== 1'b0) begin errors++; $display("FAIL reset_hazard_b got=%b want=0", hazard_b); end
    tick();
  endtask

  task automatic test_select();
    logic [4:0] want [4];
    want[0] = 5'b01010; want[1] = 5'b11111; want[2] = 5'd31; want[3] = 5'b01010;
    for (int m = 0; m < 4; m++) begin
      // in_valid low: selection must not depend on it
      drive(1'b0, 1'b0, 2'(m), 5'b01010, 5'b11111, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      checks++; if (dest_out !== want[m]) begin errors++; $display("FAIL select_mode%0d got=%b want=%b", m, dest_out, want[m]); end
      tick();
    end
    drive(1'b0, 1'b0, 2'b10, 5'b00001, 5'b00010, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (dest_out !== 5'd31) begin errors++; $display("FAIL select_link got=%b want=11111", dest_out); end
    tick();
  endtask

  task automatic test_latency();
    logic       want_wb [5];
    logic [3:0] want_if [5];
    want_wb = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    want_if = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd0};
    do_reset();
    drive(1'b1, 1'b1, 2'b01, 5'd9, 5'b00101, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) idle(5'd0, 5'd0);
      checks++; if (wb_valid !== want_wb[c]) begin errors++; $display("FAIL latency_wb_valid cyc=%0d got=%b want=%b", c, wb_valid, want_wb[c]); end
      checks++; if (inflight !== want_if[c]) begin errors++; $display("FAIL latency_inflight cyc=%0d got=%0d want=%0d", c, inflight, want_if[c]); end
      if (c == 3) begin
        checks++; if (wb_dest !== 5'b00101) begin errors++; $display("FAIL latency_wb_dest got=%b want=00101", wb_dest); end
      end
      tick();
    end
  endtask

  task automatic test_zero_write();
    do_reset();
    for (int c = 0; c < DEPTH + 2; c++) begin
      drive(1'b1, 1'b1, 2'b00, 5'd0, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL zero_inflight cyc=%0d got=%0d want=0", c, inflight); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL zero_wb_valid cyc=%0d got=%b want=0", c, wb_valid); end
      checks++; if (hazard_a !== 1'b0) begin errors++; $display("FAIL zero_hazard_a cyc=%0d got=%b want=0", c, hazard_a); end
      tick();
    end
  endtask

  task automatic test_hazard();
    do_reset();
    drive(1'b1, 1'b1, 2'b00, 5'b01000, 5'd0, 5'b01000, 5'b01001, 1'b0, 1'b0, 1'b0);
    // the entry being loaded must not flag a hazard yet
    checks++; if (hazard_a !== 1'b0) begin errors++; $display("FAIL hazard_loading got=%b want=0", hazard_a); end
    tick();
    for (int c = 1; c <= DEPTH + 1; c++) begin
      idle(5'b01000, 5'b01001);
      checks++; if (hazard_a !== (c <= DEPTH)) begin errors++; $display("FAIL hazard_a cyc=%0d got=%b want=%b", c, hazard_a, (c <= DEPTH)); end
      checks++; if (hazard_b !== 1'b0) begin errors++; $display("FAIL hazard_b cyc=%0d got=%b want=0", c, hazard_b); end
      tick();
    end
  endtask

  task automatic test_stall();
    int pulses = 0;
    do_reset();
    drive(1'b1, 1'b1, 2'b01, 5'd0, 5'd17, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    for (int c = 1; c < DEPTH; c++) begin idle(5'd0, 5'd0); tick(); end
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b1, 2'b01, 5'd0, 5'd20, 5'd17, 5'd0, 1'b1, 1'b0, 1'b0);
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL stall_wb_valid cyc=%0d got=%b want=0", c, wb_valid); end
      checks++; if (hazard_a !== 1'b1) begin errors++; $display("FAIL stall_hazard cyc=%0d got=%b want=1", c, hazard_a); end
      checks++; if (inflight !== 4'd1) begin errors++; $display("FAIL stall_inflight cyc=%0d got=%0d want=1", c, inflight); end
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      idle(5'd0, 5'd0);
      if (wb_valid === 1'b1) begin
        pulses++;
        checks++; if (wb_dest !== 5'd17) begin errors++; $display("FAIL stall_wb_dest got=%0d want=17", wb_dest); end
      end
      if (c == 0) begin
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL stall_release got=%b want=1", wb_valid); end
      end
      tick();
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL stall_pulse_count got=%0d want=1", pulses); end
  endtask

  task automatic test_flush_reset(input logic use_reset);
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b1, 2'b00, 5'(3 + c), 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 2'b00, 5'd6, 5'd0, 5'd3, 5'd5, 1'b1, ~use_reset, use_reset);
    checks++; if (inflight !== 4'd3) begin errors++; $display("FAIL kill%0d_before got=%0d want=3", use_reset, inflight); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL kill%0d_wb_now got=%b want=0", use_reset, wb_valid); end
    tick();
    for (int c = 0; c < DEPTH; c++) begin
      idle(5'd3, 5'd5);
      checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL kill%0d_inflight cyc=%0d got=%0d want=0", use_reset, c, inflight); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL kill%0d_wb cyc=%0d got=%b want=0", use_reset, c, wb_valid); end
      checks++; if (hazard_a !== 1'b0) begin errors++; $display("FAIL kill%0d_hazard cyc=%0d got=%b want=0", use_reset, c, hazard_a); end
      tick();
    end
    if (use_reset) begin
      idle(5'd0, 5'd0);
      checks++; if (wb_dest !== 5'd0) begin errors++; $display("FAIL kill_reset_wb_dest got=%0d want=0", wb_dest); end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0);
      checks++; if (dest_out !== sel_model(reg_dst, rt_addr, rd_addr)) begin errors++; $display("FAIL rand_dest_out cyc=%0d got=%0d want=%0d", c, dest_out, sel_model(reg_dst, rt_addr, rd_addr)); end
      checks++; if (wb_valid !== m_wb_valid()) begin errors++; $display("FAIL rand_wb_valid cyc=%0d got=%b want=%b", c, wb_valid, m_wb_valid()); end
      if (m_wb_valid()) begin
        checks++; if (wb_dest !== m_wb_dest()) begin errors++; $display("FAIL rand_wb_dest cyc=%0d got=%0d want=%0d", c, wb_dest, m_wb_dest()); end
      end
      checks++; if (inflight !== m_inflight()) begin errors++; $display("FAIL rand_inflight cyc=%0d got=%0d want=%0d", c, inflight, m_inflight()); end
      checks++; if (hazard_a !== m_hazard(src_a)) begin errors++; $display("FAIL rand_hazard_a cyc=%0d got=%b want=%b", c, hazard_a, m_hazard(src_a)); end
      checks++; if (hazard_b !== m_hazard(src_b)) begin errors++; $display("FAIL rand_hazard_b cyc=%0d got=%b want=%b", c, hazard_b, m_hazard(src_b)); end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; reg_write = 1'b0; reg_dst = 2'b00;
    rt_addr = '0; rd_addr = '0; src_a = '0; src_b = '0; stall = 1'b0; flush = 1'b0;
    test_reset();
    test_select();
    test_latency();
    test_zero_write();
    test_hazard();
    test_stall();
    test_flush_reset(1'b0);
    test_flush_reset(1'b1);
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
